vend_ctrl: RTL

Top-level sequencing controller for the coin-operated vending datapath. Accumulates coin deposits and detects when the price is reached. Issues a one-cycle dispense strobe, then pays change one coin per cycle. Also handles cancel and inactivity-timeout refunds, and rejects coins offered while a transaction is being closed out.

---
 rtl/vend_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl
// -----------------------------------------------------------------------------
// Sequencing controller for the coin-operated vending datapath. It accumulates
// coin deposits, fires a single-cycle dispense strobe once the price is
// reached, and then pays out any change one coin per cycle (dimes first, then
// a nickel). A customer cancel, or an inactivity timeout while collecting,
// refunds the full deposit through the same change path. Coins offered while
// a sale or refund is being paid out are rejected and not counted.
//
// Parameters
//   PRICE    item price in cents (multiple of 5, 5..40)
//   TIMEOUT  idle cycles in COLLECT before an automatic refund (>= 2)
//   CNT_W    timeout counter width, 2**CNT_W > TIMEOUT
//
// Ports
//   clk_i            system clock, rising edge
//   rst_i            synchronous active-high reset
//   nickle_i         5-cent coin strobe (highest priority)
//   dime_i           10-cent coin strobe
//   quarter_i        25-cent coin strobe (lowest priority)
//   cancel_i         cancel request, sampled every cycle
//   deposit_o        accumulated deposit in cents (deposit register)
//   soda_o           dispense strobe, one cycle per sale
//   change_nickel_o  pay one 5-cent coin this cycle
//   change_dime_o    pay one 10-cent coin this cycle
//   reject_o         a coin offered this cycle is not accepted (combinational)
//   busy_o           a sale or refund is being paid out
// -----------------------------------------------------------------------------
module vend_ctrl #(
    parameter int PRICE   = 20,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       nickle_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    input  logic       cancel_i,
    output logic [5:0] deposit_o,
    output logic       soda_o,
    output logic       change_nickel_o,
    output logic       change_dime_o,
    output logic       reject_o,
    output logic       busy_o
);

    localparam logic [5:0]       PRICE_C  = 6'(PRICE);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       deposit_q, deposit_d;
    logic [5:0]       change_q, change_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0]       coin_val;
    logic             coin_any;
    logic             coin_multi;

    // Value of the single coin accepted this cycle, honouring the
    // nickel > dime > quarter priority. Zero when no strobe is present.
    function automatic logic [5:0] coin_value(input logic n, input logic d, input logic q);
        logic [5:0] v;
        v = 6'd0;
        if (n) begin
            v = 6'd5;
        end else if (d) begin
            v = 6'd10;
        end else if (q) begin
            v = 6'd25;
        end
        return v;
    endfunction

    assign coin_val   = coin_value(nickle_i, dime_i, quarter_i);
    assign coin_any   = nickle_i | dime_i | quarter_i;
    // Only one coin is taken per cycle; any extra strobe is a reject.
    assign coin_multi = (nickle_i & dime_i) | (nickle_i & quarter_i) | (dime_i & quarter_i);

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        deposit_d       = deposit_q;
        change_d        = change_q;
        cnt_d           = cnt_q;
        soda_o          = 1'b0;
        change_nickel_o = 1'b0;
        change_dime_o   = 1'b0;
        reject_o        = 1'b0;
        busy_o          = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Cancel means nothing with an empty deposit.
                reject_o = coin_multi;
                if (coin_any) begin
                    deposit_d = coin_val;
                    cnt_d     = '0;
                    state_d   = (coin_val >= PRICE_C) ? S_DISPENSE : S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (cancel_i) begin
                    // Cancel wins over any coin offered in the same cycle.
                    reject_o  = coin_any;
                    change_d  = deposit_q;
                    deposit_d = 6'd0;
                    cnt_d     = '0;
                    state_d   = S_CHANGE;
                end else if (coin_any) begin
                    reject_o  = coin_multi;
                    deposit_d = deposit_q + coin_val;
                    cnt_d     = '0;
                    if (deposit_d >= PRICE_C) begin
                        state_d = S_DISPENSE;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    // Inactivity timeout refunds exactly like a cancel.
                    change_d  = deposit_q;
                    deposit_d = 6'd0;
                    cnt_d     = '0;
                    state_d   = S_CHANGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DISPENSE: begin
                soda_o    = 1'b1;
                busy_o    = 1'b1;
                reject_o  = coin_any;
                change_d  = deposit_q - PRICE_C;
                deposit_d = 6'd0;
                state_d   = (change_d != 6'd0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                busy_o   = 1'b1;
                reject_o = coin_any;
                // All amounts are multiples of 5, so this never underflows.
                if (change_q >= 6'd10) begin
                    change_dime_o = 1'b1;
                    change_d      = change_q - 6'd10;
                end else begin
                    change_nickel_o = 1'b1;
                    change_d        = change_q - 6'd5;
                end
                if (change_d == 6'd0) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                deposit_d = 6'd0;
                change_d  = 6'd0;
                cnt_d     = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            deposit_q <= 6'd0;
            change_q  <= 6'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            deposit_q <= deposit_d;
            change_q  <= change_d;
            cnt_q     <= cnt_d;
        end
    end

    assign deposit_o = deposit_q;

endmodule
